// File: rtl/h_sum.sv
// One-bit half adder with a zero-latency combinational path, plus a clocked
// observation stage (registered s/c and saturating activity counters).
module h_sum #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  output logic             s,
  output logic             c,
  input  logic             en,
  input  logic             clr,
  output logic             s_q,
  output logic             c_q,
  output logic [CNT_W-1:0] sum_cnt,
  output logic [CNT_W-1:0] carry_cnt,
  output logic             sum_sat,
  output logic             carry_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Adder path stays purely combinational so chained full adders see no clock or reset.
  assign s = a ^ b;
  assign c = a & b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= 1'b0;
      c_q <= 1'b0;
    end else if (en) begin
      s_q <= s;
      c_q <= c;
    end
  end

  // Counters stop at all-ones; the sticky flag rises on the edge that reaches it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_cnt   <= '0;
      carry_cnt <= '0;
      sum_sat   <= 1'b0;
      carry_sat <= 1'b0;
    end else if (clr) begin
      sum_cnt   <= '0;
      carry_cnt <= '0;
      sum_sat   <= 1'b0;
      carry_sat <= 1'b0;
    end else if (en) begin
      if (s && (sum_cnt != CNT_MAX)) begin
        sum_cnt <= sum_cnt + CNT_ONE;
        if (sum_cnt == (CNT_MAX - CNT_ONE)) sum_sat <= 1'b1;
      end
      if (c && (carry_cnt != CNT_MAX)) begin
        carry_cnt <= carry_cnt + CNT_ONE;
        if (carry_cnt == (CNT_MAX - CNT_ONE)) carry_sat <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_h_sum.sv
// Directed bench for h_sum: expectations are queued as stimulus is applied
// and popped when the corresponding output is sampled.
module tb_h_sum;

  logic clk = 1'b0;
  logic clk_run = 1'b0;
  logic rst_n = 1'b1;
  logic a = 1'b0, b = 1'b0, en = 1'b0, clr = 1'b0;

  logic s, c, s_q, c_q, sum_sat, carry_sat;
  logic [15:0] sum_cnt, carry_cnt;

  logic s2, c2, s_q2, c_q2, sum_sat2, carry_sat2;
  logic [1:0] sum_cnt2, carry_cnt2;

  logic fa_a = 1'b0, fa_b = 1'b0, fa_cin = 1'b0;
  logic h1_s, h1_c, h2_s, h2_c;
  logic h1_sq, h1_cq, h1_ss, h1_cs, h2_sq, h2_cq, h2_ss, h2_cs;
  logic [15:0] h1_sc, h1_cc, h2_sc, h2_cc;
  logic fa_carry;

  int total = 0;
  int bad = 0;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;
  exp_t sb[$];

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  h_sum dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .s(s), .c(c), .en(en), .clr(clr),
    .s_q(s_q), .c_q(c_q), .sum_cnt(sum_cnt), .carry_cnt(carry_cnt),
    .sum_sat(sum_sat), .carry_sat(carry_sat)
  );

  h_sum #(.CNT_W(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .s(s2), .c(c2), .en(en), .clr(clr),
    .s_q(s_q2), .c_q(c_q2), .sum_cnt(sum_cnt2), .carry_cnt(carry_cnt2),
    .sum_sat(sum_sat2), .carry_sat(carry_sat2)
  );

  // Full adder from two half adders and an OR on the carries.
  h_sum ha1 (
    .clk(clk), .rst_n(rst_n), .a(fa_a), .b(fa_cin), .s(h1_s), .c(h1_c),
    .en(1'b0), .clr(1'b0), .s_q(h1_sq), .c_q(h1_cq), .sum_cnt(h1_sc),
    .carry_cnt(h1_cc), .sum_sat(h1_ss), .carry_sat(h1_cs)
  );

  h_sum ha2 (
    .clk(clk), .rst_n(rst_n), .a(h1_s), .b(fa_b), .s(h2_s), .c(h2_c),
    .en(1'b0), .clr(1'b0), .s_q(h2_sq), .c_q(h2_cq), .sum_cnt(h2_sc),
    .carry_cnt(h2_cc), .sum_sat(h2_ss), .carry_sat(h2_cs)
  );

  assign fa_carry = h1_c | h2_c;

  task automatic applyStimulus(input logic ia, input logic ib, input logic ien, input logic iclr);
    a   = ia;
    b   = ib;
    en  = ien;
    clr = iclr;
  endtask

  task automatic expectVal(input string tag, input logic [31:0] value);
    exp_t e;
    e.tag   = tag;
    e.value = value;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input logic [31:0] observed);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_empty observed=%0h expected=none", observed);
    end else begin
      e = sb.pop_front();
      assert (observed === e.value) else begin
        bad++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, observed, e.value);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] ab;
    logic [2:0] fav;
    logic [1:0] fa_sum;

    $display("[TB] start");
    #2 rst_n = 1'b0;
    #2;
    expectVal("rst_s_q", 0);       checkOutput({31'd0, s_q});
    expectVal("rst_c_q", 0);       checkOutput({31'd0, c_q});
    expectVal("rst_sum_cnt", 0);   checkOutput({16'd0, sum_cnt});
    expectVal("rst_carry_cnt", 0); checkOutput({16'd0, carry_cnt});
    expectVal("rst_sats", 0);      checkOutput({30'd0, sum_sat, carry_sat});

    // Truth table, clock stopped, reset held.
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      applyStimulus(ab[1], ab[0], 1'b1, 1'b0);
      expectVal($sformatf("tt_%0d%0d", ab[1], ab[0]), {30'd0, ab[1] & ab[0], ab[1] ^ ab[0]});
      #64;
      checkOutput({30'd0, c, s});
    end

    for (int i = 0; i < 8; i++) begin
      fav = 3'(i);
      fa_a = fav[2]; fa_cin = fav[1]; fa_b = fav[0];
      fa_sum = 2'(fav[2]) + 2'(fav[1]) + 2'(fav[0]);
      expectVal($sformatf("fa_%0d", i), {30'd0, fa_sum});
      #5;
      checkOutput({30'd0, fa_carry, h2_s});
    end

    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    #1 rst_n = 1'b1;
    clk_run = 1'b1;
    tick();
    tick();
    expectVal("pre_rst_carry_cnt", 2); checkOutput({16'd0, carry_cnt});
    expectVal("pre_rst_cq", 1);        checkOutput({31'd0, c_q});

    // Mid-cycle asynchronous reset.
    #1 rst_n = 1'b0;
    #1;
    expectVal("arst_sq_cq", 0);     checkOutput({30'd0, s_q, c_q});
    expectVal("arst_carry_cnt", 0); checkOutput({16'd0, carry_cnt});
    expectVal("arst_w2_cnt", 0);    checkOutput({30'd0, carry_cnt2});
    expectVal("arst_comb_cs", 2);   checkOutput({30'd0, c, s});
    #1 rst_n = 1'b1;

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    expectVal("lat_before", 0);     checkOutput({30'd0, s_q, c_q});
    tick();
    expectVal("lat_after", 2);      checkOutput({30'd0, s_q, c_q});
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    expectVal("en0_hold", 2);       checkOutput({30'd0, s_q, c_q});
    expectVal("en0_sum_cnt", 1);    checkOutput({16'd0, sum_cnt});
    expectVal("en0_carry_cnt", 0);  checkOutput({16'd0, carry_cnt});

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    expectVal("clr_sum_cnt", 0);    checkOutput({16'd0, sum_cnt});

    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      applyStimulus(ab[1], ab[0], 1'b1, 1'b0);
      tick();
    end
    expectVal("cnt_sum", 2);        checkOutput({16'd0, sum_cnt});
    expectVal("cnt_carry", 1);      checkOutput({16'd0, carry_cnt});
    expectVal("cnt_regs", 1);       checkOutput({30'd0, s_q, c_q});
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      applyStimulus(ab[1], ab[0], 1'b0, 1'b0);
      tick();
    end
    expectVal("cnt_en0_sum", 2);    checkOutput({16'd0, sum_cnt});
    expectVal("cnt_en0_carry", 1);  checkOutput({16'd0, carry_cnt});

    // Saturation on the 2-bit instance.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      expectVal($sformatf("sat_cnt_%0d", i), (i < 3) ? i : 3);
      checkOutput({30'd0, sum_cnt2});
      expectVal($sformatf("sat_flag_%0d", i), (i < 3) ? 0 : 2);
      checkOutput({30'd0, sum_sat2, carry_sat2});
    end
    expectVal("sat_wide_cnt", 5);   checkOutput({16'd0, sum_cnt});

    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    expectVal("csat_mid", 0);       checkOutput({31'd0, carry_sat2});
    tick();
    tick();
    expectVal("csat_cnt", 3);       checkOutput({30'd0, carry_cnt2});
    expectVal("csat_flag", 1);      checkOutput({31'd0, carry_sat2});

    // clr beats a simultaneous enabled event, but s_q still updates.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    expectVal("pre_clr_sq", 0);     checkOutput({31'd0, s_q2});
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    expectVal("clrp_cnt", 0);       checkOutput({30'd0, sum_cnt2});
    expectVal("clrp_flags", 0);     checkOutput({30'd0, sum_sat2, carry_sat2});
    expectVal("clrp_sq", 1);        checkOutput({31'd0, s_q2});
    expectVal("clrp_wide_cnt", 0);  checkOutput({16'd0, sum_cnt});
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    expectVal("post_clr_cnt", 1);   checkOutput({30'd0, sum_cnt2});

    if (sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
